// File: rtl/bit_step_scheduler_pkg.sv
// ============================================================
// bit_step_scheduler_pkg: shared phase constants and states
// Rev 1.0
// ============================================================
`default_nettype none

package bit_step_scheduler_pkg;

  localparam int NUM_PHASES = 6;

  localparam logic [7:0] PAT_0 = 8'h90;
  localparam logic [7:0] PAT_1 = 8'h18;
  localparam logic [7:0] PAT_2 = 8'h48;
  localparam logic [7:0] PAT_3 = 8'h60;
  localparam logic [7:0] PAT_4 = 8'h24;
  localparam logic [7:0] PAT_5 = 8'h84;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_DEAD  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Mod-6 step; dir=1 walks backwards.
  function automatic logic [2:0] next_phase(input logic [2:0] cur, input logic dir);
    logic [2:0] nxt;
    if (dir) nxt = (cur == 3'd0) ? 3'(NUM_PHASES - 1) : cur - 3'd1;
    else     nxt = (cur == 3'(NUM_PHASES - 1)) ? 3'd0 : cur + 3'd1;
    return nxt;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bit_phase_rom.sv
// ============================================================
// bit_phase_rom: phase index -> 8-bit drive pattern, blankable
// Rev 1.0
// ============================================================
`default_nettype none

module bit_phase_rom
  import bit_step_scheduler_pkg::*;
(
  input  logic [2:0] phase,
  input  logic       blank,
  output logic [7:0] pattern
);

  always_comb begin
    pattern = 8'h00;
    if (!blank) begin
      case (phase)
        3'd0:    pattern = PAT_0;
        3'd1:    pattern = PAT_1;
        3'd2:    pattern = PAT_2;
        3'd3:    pattern = PAT_3;
        3'd4:    pattern = PAT_4;
        3'd5:    pattern = PAT_5;
        default: pattern = 8'h00;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/bit_step_scheduler.sv
// ============================================================
// bit_step_scheduler: command-driven 6-phase pattern sequencer
// Rev 1.0
// ============================================================
`default_nettype none

module bit_step_scheduler
  import bit_step_scheduler_pkg::*;
#(
  parameter int PERIOD_W    = 16,
  parameter int COUNT_W     = 12,
  parameter int DEAD_CYCLES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_dir,
  input  logic [COUNT_W-1:0]  cmd_steps,
  input  logic [PERIOD_W-1:0] cmd_period,
  input  logic                abort,
  output logic [7:0]          out,
  output logic [2:0]          phase,
  output logic                busy,
  output logic                done
);

  localparam logic [PERIOD_W-1:0] DEAD_LOAD = PERIOD_W'(DEAD_CYCLES);
  localparam logic [PERIOD_W-1:0] ONE_P     = PERIOD_W'(1);
  localparam logic [COUNT_W-1:0]  ONE_C     = COUNT_W'(1);

  state_t              state, state_n;
  logic [2:0]          phase_n;
  logic [PERIOD_W-1:0] timer, timer_n;
  logic [PERIOD_W-1:0] period, period_n;
  logic [COUNT_W-1:0]  remaining, remaining_n;
  logic                dir, dir_n;
  logic                advance;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      phase     <= 3'd0;
      timer     <= '0;
      period    <= ONE_P;
      remaining <= '0;
      dir       <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      timer     <= timer_n;
      period    <= period_n;
      remaining <= remaining_n;
      dir       <= dir_n;
    end
  end

  always_comb begin
    state_n     = state;
    phase_n     = phase;
    timer_n     = timer;
    period_n    = period;
    remaining_n = remaining;
    dir_n       = dir;
    advance     = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          dir_n       = cmd_dir;
          period_n    = (cmd_period == '0) ? ONE_P : cmd_period;
          remaining_n = cmd_steps;
          if (cmd_steps == '0) begin
            state_n = ST_DONE;
          end else begin
            state_n = ST_DWELL;
            timer_n = period_n;
          end
        end
      end
      ST_DWELL: begin
        if (abort) begin
          state_n     = ST_DONE;
          remaining_n = '0;
          timer_n     = '0;
        end else if (timer <= ONE_P) begin
          if (DEAD_CYCLES > 0) begin
            state_n = ST_DEAD;
            timer_n = DEAD_LOAD;
          end else begin
            advance = 1'b1;
          end
        end else begin
          timer_n = timer - ONE_P;
        end
      end
      ST_DEAD: begin
        if (abort) begin
          state_n     = ST_DONE;
          remaining_n = '0;
          timer_n     = '0;
        end else if (timer <= ONE_P) begin
          advance = 1'b1;
        end else begin
          timer_n = timer - ONE_P;
        end
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase

    // A completed step either finishes the command or starts the next dwell.
    if (advance) begin
      phase_n     = next_phase(phase, dir);
      remaining_n = remaining - ONE_C;
      if (remaining == ONE_C) begin
        state_n = ST_DONE;
        timer_n = '0;
      end else begin
        state_n = ST_DWELL;
        timer_n = period;
      end
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state == ST_DWELL) || (state == ST_DEAD);
  assign done      = (state == ST_DONE);

  bit_phase_rom u_rom (
    .phase   (phase),
    .blank   (state == ST_DEAD),
    .pattern (out)
  );

endmodule

`default_nettype wire

// File: tb/tb_bit_step_scheduler.sv
// Directed bench for bit_step_scheduler (DEAD_CYCLES=2).
`default_nettype none

module tb_bit_step_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_dir;
  logic [11:0] cmd_steps;
  logic [15:0] cmd_period;
  logic        abort;
  logic [7:0]  out;
  logic [2:0]  phase;
  logic        busy;
  logic        done;

  int vectors = 0;
  int miscompares = 0;

  logic [7:0] pat [6];

  always #5 clk = ~clk;

  bit_step_scheduler #(.PERIOD_W(16), .COUNT_W(12), .DEAD_CYCLES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_dir    (cmd_dir),
    .cmd_steps  (cmd_steps),
    .cmd_period (cmd_period),
    .abort      (abort),
    .out        (out),
    .phase      (phase),
    .busy       (busy),
    .done       (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic issue(input logic d, input logic [11:0] n, input logic [15:0] p);
    cmd_valid  = 1'b1;
    cmd_dir    = d;
    cmd_steps  = n;
    cmd_period = p;
    tick();
    cmd_valid  = 1'b0;
  endtask

  initial begin
    logic [7:0] e;
    pat[0] = 8'h90; pat[1] = 8'h18; pat[2] = 8'h48;
    pat[3] = 8'h60; pat[4] = 8'h24; pat[5] = 8'h84;
    reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0;
    cmd_steps = '0; cmd_period = '0; abort = 1'b0;

    // 1. reset values
    do_reset();
    check_eq("rst_out", out, 8'h90);
    check_eq("rst_phase", phase, 3'd0);
    check_eq("rst_ready", cmd_ready, 1'b1);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);

    // 2. fwd 3 steps, period 4: each step is 4 dwell + 2 dead
    issue(1'b0, 12'd3, 16'd4);
    for (int i = 0; i < 18; i++) begin
      e = ((i % 6) < 4) ? pat[i / 6] : 8'h00;
      check_eq("fwd3_out", out, e);
      check_eq("fwd3_nodone", done, 1'b0);
      tick();
    end
    check_eq("fwd3_done", done, 1'b1);
    check_eq("fwd3_phase", phase, 3'd3);
    check_eq("fwd3_final_out", out, 8'h60);
    check_eq("fwd3_ready_in_done", cmd_ready, 1'b0);
    tick();
    check_eq("fwd3_done_once", done, 1'b0);
    check_eq("fwd3_ready_back", cmd_ready, 1'b1);
    check_eq("idle_hold_out", out, 8'h60);

    // 3. rev 2 steps period 1 from phase 0
    do_reset();
    issue(1'b1, 12'd2, 16'd1);
    check_eq("rev_s0", out, 8'h90); tick();
    check_eq("rev_s1", out, 8'h00); tick();
    check_eq("rev_s2", out, 8'h00); tick();
    check_eq("rev_s3", out, 8'h84);
    check_eq("rev_ph5", phase, 3'd5); tick();
    check_eq("rev_s4", out, 8'h00); tick();
    check_eq("rev_s5", out, 8'h00); tick();
    check_eq("rev_done", done, 1'b1);
    check_eq("rev_out", out, 8'h24);
    check_eq("rev_phase", phase, 3'd4);
    tick();
    check_eq("rev_done_once", done, 1'b0);

    // 4. fwd 7 steps period 0 (treated as 1): wraps 5 -> 0
    do_reset();
    issue(1'b0, 12'd7, 16'd0);
    for (int i = 0; i < 21; i++) begin
      if (i == 2)  check_eq("p0_dead", out, 8'h00);
      if (i == 3)  check_eq("p0_step1", out, 8'h18);
      if (i == 15) check_eq("p0_step5", out, 8'h84);
      if (i == 18) check_eq("p0_wrap", phase, 3'd0);
      check_eq("p0_busy", busy, 1'b1);
      tick();
    end
    check_eq("p0_done", done, 1'b1);
    check_eq("p0_phase", phase, 3'd1);
    check_eq("p0_out", out, 8'h18);
    tick();

    // 5. abort during dead time of step 2
    do_reset();
    issue(1'b0, 12'd3, 16'd2);
    for (int i = 0; i < 6; i++) tick();
    check_eq("ab_in_dead", out, 8'h00);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_eq("ab_done", done, 1'b1);
    check_eq("ab_out", out, 8'h18);
    check_eq("ab_phase", phase, 3'd1);
    tick();
    check_eq("ab_idle", cmd_ready, 1'b1);
    check_eq("ab_done_once", done, 1'b0);
    issue(1'b0, 12'd0, 16'd5);
    check_eq("z_done", done, 1'b1);
    check_eq("z_out", out, 8'h18);
    tick();
    check_eq("z_idle", cmd_ready, 1'b1);
    abort = 1'b1;
    issue(1'b0, 12'd1, 16'd1);
    abort = 1'b0;
    check_eq("abidle_accept", busy, 1'b1);
    tick(); tick(); tick();
    check_eq("abidle_done", done, 1'b1);
    check_eq("abidle_phase", phase, 3'd2);
    tick();

    // 6. reset mid-dwell with cmd_valid held high
    issue(1'b0, 12'd5, 16'd10);
    tick(); tick();
    check_eq("mid_busy", busy, 1'b1);
    cmd_valid = 1'b1;
    reset = 1'b1;
    tick();
    check_eq("mr_out", out, 8'h90);
    check_eq("mr_phase", phase, 3'd0);
    check_eq("mr_ready", cmd_ready, 1'b1);
    check_eq("mr_busy", busy, 1'b0);
    tick();
    check_eq("mr_hold_busy", busy, 1'b0);
    reset = 1'b0;
    tick();
    check_eq("mr_accept", busy, 1'b1);
    cmd_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
